// File: rtl/fir_pkg.sv
// Shared defaults and state encoding for the serial FIR front end.
package fir_pkg;

    localparam int FIR_DATA_W     = 18;
    localparam int FIR_TAPS       = 128;
    localparam int FIR_FIFO_DEPTH = 16;

    typedef enum logic {
        WAIT = 1'b0,
        MAC  = 1'b1
    } feed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: rd_data always presents the head entry, pop just advances.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
    assign do_push = push && (count != FULL_LEVEL);
    assign do_pop  = pop && (count != '0);

    assign full    = (count == FULL_LEVEL);
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds the serial FIR one buffered sample per TAPS-cycle frame, in lockstep with its tap index.
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int DATA_W     = FIR_DATA_W,
    parameter int TAPS       = FIR_TAPS,
    parameter int FIFO_DEPTH = FIR_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DATA_W-1:0]             fir_sig,
    output logic                          fir_ready,
    output logic                          frame_start,
    output logic                          result_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   stall_cnt
);

    localparam int PW = $clog2(TAPS);
    localparam logic [PW-1:0] PHASE_LAST   = PW'(TAPS - 1);
    localparam logic [PW-1:0] PHASE_PENULT = PW'(TAPS - 2);

    feed_state_t       state;
    feed_state_t       state_next;
    logic [PW-1:0]     phase;
    logic              first_frame;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              stall_now;
    logic [DATA_W-1:0] fifo_head;

    assign s_ready     = !fifo_full;
    assign push        = s_valid && !fifo_full;
    assign fir_sig     = fifo_empty ? '0 : fifo_head;
    assign frame_start = pop;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (s_data),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // The filter latches fir_sig on the same edge that pops it, so the pop and the
    // enable that starts a frame are one signal; reset holds the filter frozen.
    always_comb begin
        state_next = state;
        fir_ready  = 1'b0;
        pop        = 1'b0;
        stall_now  = 1'b0;
        if (!rst) begin
            case (state)
                WAIT: begin
                    if (!fifo_empty) begin
                        fir_ready  = 1'b1;
                        pop        = 1'b1;
                        state_next = MAC;
                    end else begin
                        stall_now  = 1'b1;
                    end
                end
                MAC: begin
                    fir_ready = 1'b1;
                    if (phase == PHASE_PENULT) begin
                        state_next = WAIT;
                    end
                end
                default: state_next = WAIT;
            endcase
        end
    end

    // phase shadows the filter's tap index, which also starts at TAPS-1 and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT;
            phase        <= PHASE_LAST;
            first_frame  <= 1'b1;
            result_valid <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            state        <= state_next;
            result_valid <= pop && !first_frame;
            if (fir_ready) begin
                phase <= phase + 1'b1;
            end
            if (pop) begin
                first_frame <= 1'b0;
            end
            if (stall_now && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder: handover timing, frame period, FIFO limits, stalls and reset.
module tb_fir_sample_feeder;
    import fir_pkg::*;

    localparam int DW    = FIR_DATA_W;
    localparam int TAPS  = FIR_TAPS;
    localparam int DEPTH = FIR_FIFO_DEPTH;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] fir_sig;
    logic          fir_ready;
    logic          frame_start;
    logic          result_valid;
    logic [LW-1:0] fifo_level;
    logic [15:0]   stall_cnt;

    int testCount = 0;
    int failCount = 0;
    int cycleNo   = 0;
    int lastPop   = 0;
    logic signed [DW-1:0] popLog [$];

    logic signed [DW-1:0] burst5 [5] = '{18'sd11, -18'sd22, 18'sd333, -18'sd4444, 18'sd55555};
    logic signed [DW-1:0] burst20 [20];
    logic signed [DW-1:0] quad [4] = '{18'sd101, -18'sd202, 18'sd303, -18'sd404};

    fir_sample_feeder #(
        .DATA_W     (DW),
        .TAPS       (TAPS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .fir_sig      (fir_sig),
        .fir_ready    (fir_ready),
        .frame_start  (frame_start),
        .result_valid (result_valid),
        .fifo_level   (fifo_level),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    always @(negedge clk) begin
        if (frame_start === 1'b1) popLog.push_back($signed(fir_sig));
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic signed [DW-1:0] d);
        s_valid = v;
        s_data  = d;
    endtask

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Advances to the next pop, then checks its spacing, its data and the following result pulse.
    task automatic waitPop(input string tag, input int expGap, input logic signed [DW-1:0] expData,
                           input logic expRv);
        int n;
        n = 0;
        tick();
        settle();
        while (frame_start !== 1'b1 && n < 4 * TAPS) begin
            tick();
            settle();
            n++;
        end
        checkOutput({tag, "_gap"}, cycleNo - lastPop, expGap);
        lastPop = cycleNo;
        checkOutput({tag, "_data"}, $signed(fir_sig), expData);
        tick();
        settle();
        checkOutput({tag, "_rv"}, result_valid, expRv);
    endtask

    initial begin
        int hiCount;
        int rvCount;
        int fsCount;
        int peak;
        int maxLvl;
        int lowCount;
        int n;
        logic popWhileFull;
        logic sawFullPop;

        for (int k = 0; k < 20; k++) burst20[k] = DW'(k * 1111 - 9000);
        burst20[0]  = -18'sd131072;
        burst20[19] = 18'sd131071;

        // Reset state
        doReset();
        settle();
        checkOutput("rst_s_ready", s_ready, 1);
        checkOutput("rst_fir_ready", fir_ready, 0);
        checkOutput("rst_frame_start", frame_start, 0);
        checkOutput("rst_result_valid", result_valid, 0);
        checkOutput("rst_fifo_level", fifo_level, 0);
        checkOutput("rst_stall_cnt", stall_cnt, 0);
        checkOutput("rst_fir_sig", $signed(fir_sig), 0);

        // Test 1: single sample handover one cycle after the push
        tick();
        applyStimulus(1'b1, 18'sd1000);
        settle();
        checkOutput("t1_no_pop_on_push", frame_start, 0);
        tick();
        applyStimulus(1'b0, '0);
        settle();
        checkOutput("t1_pop", frame_start, 1);
        checkOutput("t1_fir_sig", $signed(fir_sig), 1000);
        checkOutput("t1_stall_two_idle", stall_cnt, 2);
        lastPop = cycleNo;

        // Test 2 pushes its five samples while frame one is still running
        hiCount = 0;
        rvCount = 0;
        fsCount = 0;
        peak    = 0;
        for (int i = 0; i < TAPS; i++) begin
            if (i > 0) begin
                tick();
                if (i >= 10 && i < 15) applyStimulus(1'b1, burst5[i-10]);
                else applyStimulus(1'b0, '0);
                settle();
            end
            if (fir_ready === 1'b1) hiCount++;
            if (result_valid === 1'b1) rvCount++;
            if (frame_start === 1'b1) fsCount++;
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        checkOutput("t1_fir_ready_run", hiCount, TAPS);
        checkOutput("t1_no_result_valid", rvCount, 0);
        checkOutput("t1_single_frame_start", fsCount, 1);
        checkOutput("t2_level_peak", peak, 5);

        for (int k = 0; k < 5; k++) begin
            waitPop($sformatf("t2_pop%0d", k + 2), TAPS, burst5[k], 1'b1);
        end

        // Test 3: 20-sample burst with s_valid held through back-pressure
        popLog.delete();
        maxLvl     = 0;
        sawFullPop = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            applyStimulus(1'b1, burst20[k]);
            settle();
            if (k == DEPTH - 1) begin
                checkOutput("t3_level_15", fifo_level, DEPTH - 1);
                checkOutput("t3_s_ready_at_15", s_ready, 1);
            end
            if (k == DEPTH) begin
                checkOutput("t3_level_16", fifo_level, DEPTH);
                checkOutput("t3_s_ready_at_16", s_ready, 0);
            end
            n = 0;
            while (s_ready !== 1'b1 && n < 4 * TAPS) begin
                if (int'(fifo_level) > maxLvl) maxLvl = int'(fifo_level);
                popWhileFull = (frame_start === 1'b1);
                tick();
                settle();
                n++;
                if (popWhileFull && !sawFullPop) begin
                    sawFullPop = 1'b1;
                    checkOutput("t3_no_push_when_full", fifo_level, DEPTH - 1);
                end
            end
            if (int'(fifo_level) > maxLvl) maxLvl = int'(fifo_level);
        end
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("t3_max_level", maxLvl, DEPTH);
        n = 0;
        while (popLog.size() < 20 && n < 24 * TAPS) begin
            tick();
            n++;
        end
        checkOutput("t3_pop_count", popLog.size(), 20);
        for (int k = 0; k < 20 && k < popLog.size(); k++) begin
            checkOutput($sformatf("t3_order%0d", k), popLog[k], burst20[k]);
        end

        // Test 4: starve the FIFO for 50 cycles after a frame
        doReset();
        applyStimulus(1'b1, 18'sd777);
        settle();
        tick();
        applyStimulus(1'b0, '0);
        settle();
        checkOutput("t4_pop", frame_start, 1);
        checkOutput("t4_fir_sig", $signed(fir_sig), 777);
        checkOutput("t4_stall_before", stall_cnt, 1);
        repeat (TAPS - 1) tick();
        settle();
        checkOutput("t4_last_mac_ready", fir_ready, 1);
        lowCount = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            settle();
            if (fir_ready === 1'b0) lowCount++;
        end
        checkOutput("t4_fir_ready_low", lowCount, 50);
        tick();
        applyStimulus(1'b1, -18'sd12345);
        settle();
        checkOutput("t4_stall_cnt", stall_cnt, 1 + 50);
        checkOutput("t4_push_cycle_no_pop", frame_start, 0);
        tick();
        applyStimulus(1'b0, '0);
        settle();
        checkOutput("t4_resume_pop", frame_start, 1);
        checkOutput("t4_resume_sig", $signed(fir_sig), -12345);
        tick();
        settle();
        checkOutput("t4_resume_rv", result_valid, 1);

        // Test 5: reset mid-frame with three samples queued
        for (int k = 0; k < 3; k++) begin
            tick();
            applyStimulus(1'b1, DW'(k + 40));
        end
        tick();
        applyStimulus(1'b0, '0);
        repeat (55) tick();
        settle();
        checkOutput("t5_level_before", fifo_level, 3);
        checkOutput("t5_mac_before", fir_ready, 1);
        tick();
        rst = 1'b1;
        settle();
        checkOutput("t5_ready_in_reset", fir_ready, 0);
        checkOutput("t5_no_pop_in_reset", frame_start, 0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 18'sd999);
        settle();
        checkOutput("t5_ready_after", fir_ready, 0);
        checkOutput("t5_level_after", fifo_level, 0);
        checkOutput("t5_stall_after", stall_cnt, 0);
        tick();
        applyStimulus(1'b0, '0);
        settle();
        checkOutput("t5_first_pop", frame_start, 1);
        checkOutput("t5_first_sig", $signed(fir_sig), 999);
        tick();
        settle();
        checkOutput("t5_no_rv_first", result_valid, 0);

        // Test 6: push and pop on the same cycle at level 4
        for (int k = 0; k < 4; k++) begin
            tick();
            applyStimulus(1'b1, quad[k]);
        end
        tick();
        applyStimulus(1'b0, '0);
        settle();
        checkOutput("t6_level_filled", fifo_level, 4);
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 2 * TAPS);
        applyStimulus(1'b1, 18'sd4242);
        settle();
        checkOutput("t6_pop_seen", frame_start, 1);
        checkOutput("t6_level_at_pop", fifo_level, 4);
        checkOutput("t6_pop_data", $signed(fir_sig), 101);
        lastPop = cycleNo;
        tick();
        applyStimulus(1'b0, '0);
        settle();
        checkOutput("t6_level_unchanged", fifo_level, 4);
        waitPop("t6_pop2", TAPS, quad[1], 1'b1);
        waitPop("t6_pop3", TAPS, quad[2], 1'b1);
        waitPop("t6_pop4", TAPS, quad[3], 1'b1);
        waitPop("t6_marker", TAPS, 18'sd4242, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
